reg_bus_arbiter: RTL and testbench

Round-robin arbiter that shares one register-control slave bus between NUM_REQ requesters. It sits in front of the register block, serialises requester transactions onto the slave's addr/sel/wr/wdata bus, and follows the slave's ready handshake. It returns read data and a one-cycle completion pulse to the winning requester.

---
 rtl/reg_bus_arbiter_if.sv | 35 +++
 rtl/reg_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_reg_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_arbiter_if.sv
// Requester-side and slave-side signal bundle for reg_bus_arbiter.
// master = arbiter view, slave = requesters plus register block view.
interface reg_bus_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [ADDR_WIDTH-1:0]         m_addr;
  logic                          m_sel;
  logic                          m_wr;
  logic [DATA_WIDTH-1:0]         m_wdata;
  logic [DATA_WIDTH-1:0]         m_rdata;
  logic                          m_ready;

  modport master (
    input  req, req_wr, req_addr, req_wdata,
    input  m_rdata, m_ready,
    output gnt, done, rsp_rdata,
    output m_addr, m_sel, m_wr, m_wdata
  );

  modport slave (
    output req, req_wr, req_addr, req_wdata,
    output m_rdata, m_ready,
    input  gnt, done, rsp_rdata,
    input  m_addr, m_sel, m_wr, m_wdata
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one
// register slave bus with a ready handshake and one-cycle done pulse.
module reg_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input logic              clk,
  input logic              rstn,
  reg_bus_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RWAIT = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  sel_q, sel_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  found;
  logic [IW-1:0]         pick;
  logic [IW-1:0]         nxt_ptr;
  int                    j;

  // first pending requester at or after ptr_q, wrapping
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign nxt_ptr = (idx_q == IW'(NUM_REQ - 1)) ?
                   '0 : idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = ISSUE;
          idx_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          sel_d       = 1'b1;
          wr_d        = bus.req_wr[pick];
          addr_d      = bus.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d     = bus.req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ISSUE: begin
        if (bus.m_ready) begin
          if (wr_q) begin
            state_d       = IDLE;
            done_d[idx_q] = 1'b1;
            sel_d         = 1'b0;
            gnt_d         = '0;
            ptr_d         = nxt_ptr;
          end else begin
            state_d = RWAIT;
          end
        end
      end
      RWAIT: begin
        state_d       = IDLE;
        rdata_d       = bus.m_rdata;
        done_d[idx_q] = 1'b1;
        sel_d         = 1'b0;
        gnt_d         = '0;
        ptr_d         = nxt_ptr;
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.m_sel     = sel_q;
  assign bus.m_wr      = wr_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = wdata_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration and the slave.
module tb_reg_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int OW = 2*N + 2 + AW + 2*DW;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  reg_bus_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  reg_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] mem [256];

  // reference model: owner index, read-data-pending flag, rr pointer
  int            own;
  int            ptr;
  bit            rd_pend;
  bit            rd_new;
  logic [N-1:0]  e_gnt, e_done;
  logic          e_sel, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  int            stall_left = 0;
  int            stall_pct  = 0;

  task automatic model_reset();
    own = -1; ptr = 0; rd_pend = 0; rd_new = 0;
    e_gnt = '0; e_done = '0; e_sel = 0; e_wr = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  task automatic model_release();
    e_done      = '0;
    e_done[own] = 1'b1;
    ptr         = (own + 1) % N;
    own         = -1;
    rd_pend     = 0;
    e_gnt       = '0;
    e_sel       = 1'b0;
  endtask

  task automatic tick();
    logic [N-1:0]    rq, rw;
    logic [N*AW-1:0] ra;
    logic [N*DW-1:0] rd;
    logic            rdy, rs;
    logic [DW-1:0]   rdat;
    rq = bus.req; rw = bus.req_wr; ra = bus.req_addr; rd = bus.req_wdata;
    rdy = bus.m_ready; rdat = bus.m_rdata; rs = rstn;
    @(posedge clk);
    rd_new = 0;
    e_done = '0;
    if (!rs) begin
      model_reset();
    end else if (own < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (own < 0 && rq[c]) own = c;
      end
      if (own >= 0) begin
        e_gnt = '0; e_gnt[own] = 1'b1; e_sel = 1'b1;
        e_wr = rw[own]; e_addr = ra[own*AW +: AW]; e_wdata = rd[own*DW +: DW];
      end
    end else if (rd_pend) begin
      e_rdata = rdat;
      model_release();
    end else if (rdy) begin
      if (e_wr) begin
        mem[e_addr] = e_wdata;
        model_release();
      end else begin
        rd_pend = 1; rd_new = 1;
      end
    end
    #1;
    if (rd_new) begin
      bus.m_ready = 1'b0;
      bus.m_rdata = mem[e_addr];
    end else begin
      bus.m_rdata = DW'($urandom);
      if (stall_left > 0) begin
        bus.m_ready = 1'b0;
        stall_left--;
      end else begin
        bus.m_ready = ($urandom_range(99) >= stall_pct);
      end
    end
  endtask

  function automatic int oh2i(logic [N-1:0] v);
    oh2i = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) oh2i = i;
  endfunction

  task automatic set_cmd(int i, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    bus.req_wr[i]              = w;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic new_cmd(int i);
    set_cmd(i, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
  endtask

  // run until a done pulse (bounded); report first grant and done index
  task automatic serve(input bit keep, output int g, output int d);
    g = -1; d = -1;
    for (int c = 0; c < 30 && d < 0; c++) begin
      tick();
      if (g < 0 && bus.gnt != '0) g = oh2i(bus.gnt);
      if (bus.done != '0) begin
        d = oh2i(bus.done);
        if (!keep) bus.req[d] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    rstn = 1'b0;
    model_reset();
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_wr = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.m_ready = 1'b1; bus.m_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    #2;
    do_reset();
    n_cmp++;
    if (bus.gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_cmp++;
    if (bus.done !== 4'b0) begin n_err++; $display("FAIL reset_done: got %b want 0000", bus.done); end
    n_cmp++;
    if (bus.m_sel !== 1'b0) begin n_err++; $display("FAIL reset_sel: got %b want 0", bus.m_sel); end
    n_cmp++;
    if ({bus.m_wr, bus.m_addr, bus.m_wdata} !== 25'h0) begin
      n_err++; $display("FAIL reset_cmd: got %b/%h/%h want 0/00/0000", bus.m_wr, bus.m_addr, bus.m_wdata);
    end
    n_cmp++;
    if (bus.rsp_rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0000", bus.rsp_rdata); end
  endtask

  task automatic test_single_write();
    stall_pct = 0;
    set_cmd(1, 1'b1, 8'h02, 16'hBEEF);
    bus.req[1] = 1'b1;
    tick();
    n_cmp++;
    if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL wr_gnt: got %b want 0010", bus.gnt); end
    n_cmp++;
    if ({bus.m_sel, bus.m_wr, bus.m_addr, bus.m_wdata} !== {2'b11, 8'h02, 16'hBEEF}) begin
      n_err++; $display("FAIL wr_cmd: got sel=%b wr=%b %h/%h want 1 1 02/beef", bus.m_sel, bus.m_wr, bus.m_addr, bus.m_wdata);
    end
    tick();
    n_cmp++;
    if (bus.done !== 4'b0010) begin n_err++; $display("FAIL wr_done: got %b want 0010", bus.done); end
    n_cmp++;
    if ({bus.m_sel, bus.gnt} !== 5'b0) begin n_err++; $display("FAIL wr_release: got sel=%b gnt=%b want 0 0000", bus.m_sel, bus.gnt); end
    bus.req[1] = 1'b0;
    tick();
    n_cmp++;
    if ({bus.done, bus.m_sel} !== 5'b0) begin n_err++; $display("FAIL wr_single: got done=%b sel=%b want 0000 0", bus.done, bus.m_sel); end
  endtask

  task automatic test_single_read();
    mem[8'h01] = 16'h1234;
    set_cmd(2, 1'b0, 8'h01, 16'h0);
    bus.req[2] = 1'b1;
    tick();
    n_cmp++;
    if ({bus.gnt, bus.m_sel, bus.m_wr, bus.m_addr} !== {4'b0100, 2'b10, 8'h01}) begin
      n_err++; $display("FAIL rd_issue: got gnt=%b sel=%b wr=%b a=%h want 0100 1 0 01", bus.gnt, bus.m_sel, bus.m_wr, bus.m_addr);
    end
    tick();
    n_cmp++;
    if ({bus.m_sel, bus.done} !== 5'b10000) begin n_err++; $display("FAIL rd_wait: got sel=%b done=%b want 1 0000", bus.m_sel, bus.done); end
    tick();
    n_cmp++;
    if ({bus.done, bus.m_sel, bus.rsp_rdata} !== {4'b0100, 1'b0, 16'h1234}) begin
      n_err++; $display("FAIL rd_done: got done=%b sel=%b d=%h want 0100 0 1234", bus.done, bus.m_sel, bus.rsp_rdata);
    end
    bus.req[2] = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bus.done, bus.rsp_rdata} !== {4'b0, 16'h1234}) begin
      n_err++; $display("FAIL rd_hold: got done=%b d=%h want 0000 1234", bus.done, bus.rsp_rdata);
    end
  endtask

  task automatic test_contention();
    int g, d;
    do_reset();
    stall_pct = 0;
    set_cmd(0, 1'b1, 8'h10, 16'h1111);
    set_cmd(1, 1'b0, 8'h01, 16'h0);
    set_cmd(2, 1'b1, 8'h12, 16'h2222);
    set_cmd(3, 1'b0, 8'h02, 16'h0);
    bus.req = 4'hF;
    for (int k = 0; k < N; k++) begin
      serve(1'b0, g, d);
      n_cmp++;
      if (g !== k || d !== k) begin n_err++; $display("FAIL cont_order%0d: got gnt=%0d done=%0d want %0d", k, g, d, k); end
    end
    bus.req[3] = 1'b1;
    bus.req[0] = 1'b1;
    serve(1'b0, g, d);
    n_cmp++;
    if (g !== 0 || d !== 0) begin n_err++; $display("FAIL cont_wrap0: got gnt=%0d done=%0d want 0", g, d); end
    serve(1'b0, g, d);
    n_cmp++;
    if (g !== 3 || d !== 3) begin n_err++; $display("FAIL cont_wrap3: got gnt=%0d done=%0d want 3", g, d); end
  endtask

  task automatic test_fairness();
    int g, d, want;
    set_cmd(0, 1'b1, 8'h20, 16'hAAAA);
    set_cmd(2, 1'b0, 8'h21, 16'h0);
    bus.req[0] = 1'b1;
    bus.req[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve(1'b1, g, d);
      want = (k % 2 == 0) ? 0 : 2;
      n_cmp++;
      if (d !== want) begin n_err++; $display("FAIL fair%0d: got done=%0d want %0d", k, d, want); end
    end
    bus.req = '0;
    repeat (2) tick();
  endtask

  task automatic test_stall();
    int  sel_n, done_n;
    bit  stable;
    sel_n = 0; done_n = 0; stable = 1;
    stall_pct = 0;
    set_cmd(1, 1'b1, 8'h33, 16'hA5A5);
    bus.req[1] = 1'b1;
    stall_left = 3;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.m_sel) begin
        sel_n++;
        if ({bus.m_wr, bus.m_addr, bus.m_wdata} !== {1'b1, 8'h33, 16'hA5A5}) stable = 0;
        if (bus.req[1]) set_cmd(1, 1'b0, 8'h77, 16'h5A5A);
      end
      if (bus.done != '0) begin
        done_n++;
        if (bus.done !== 4'b0010) stable = 0;
        bus.req[1] = 1'b0;
      end
    end
    n_cmp++;
    if (sel_n != 4) begin n_err++; $display("FAIL stall_sel: got %0d cycles want 4", sel_n); end
    n_cmp++;
    if (done_n != 1) begin n_err++; $display("FAIL stall_done: got %0d pulses want 1", done_n); end
    n_cmp++;
    if (!stable) begin n_err++; $display("FAIL stall_stable: got unstable command want stable"); end
  endtask

  task automatic test_reset_mid_read();
    int g, d;
    set_cmd(1, 1'b0, 8'h05, 16'h0);
    bus.req[1] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.m_sel !== 1'b1) begin n_err++; $display("FAIL mid_rwait: got sel=%b want 1", bus.m_sel); end
    rstn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.gnt, bus.done, bus.m_sel, bus.m_wr, bus.m_addr, bus.m_wdata, bus.rsp_rdata} !== '0) begin
      n_err++; $display("FAIL mid_async: got gnt=%b done=%b sel=%b want all zero", bus.gnt, bus.done, bus.m_sel);
    end
    bus.req[1] = 1'b0;
    tick();
    n_cmp++;
    if (bus.done !== 4'b0) begin n_err++; $display("FAIL mid_nodone: got %b want 0000", bus.done); end
    tick();
    rstn = 1'b1;
    set_cmd(3, 1'b1, 8'h44, 16'h4444);
    bus.req[3] = 1'b1;
    serve(1'b0, g, d);
    n_cmp++;
    if (g !== 3 || d !== 3) begin n_err++; $display("FAIL mid_after: got gnt=%0d done=%0d want 3", g, d); end
  endtask

  task automatic test_random();
    logic [OW-1:0] obs, exp;
    do_reset();
    stall_pct = 30;
    for (int c = 0; c < 400; c++) begin
      tick();
      obs = {bus.gnt, bus.done, bus.m_sel, bus.m_wr, bus.m_addr, bus.m_wdata, bus.rsp_rdata};
      exp = {e_gnt, e_done, e_sel, e_wr, e_addr, e_wdata, e_rdata};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL rand_cyc%0d: got %h want %h", c, obs, exp);
      end
      for (int i = 0; i < N; i++) begin
        if (e_done[i]) begin
          if ($urandom_range(1) == 1) new_cmd(i);
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i]) begin
          if ($urandom_range(3) == 0) begin new_cmd(i); bus.req[i] = 1'b1; end
        end else if (own == i) begin
          new_cmd(i);
          if ($urandom_range(19) == 0) bus.req[i] = 1'b0;
        end
      end
    end
    bus.req = '0;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_fairness();
    test_stall();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
